// File: rtl/onehot_decoder_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : onehot_decoder_seq_if
// Brief    : Request handshake bundle feeding the sequenced one-hot decoder.
// Revision : 1.0 - initial release
// ============================================================================
interface onehot_decoder_seq_if #(
    parameter int IN_W   = 3,
    parameter int HOLD_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_code;
    logic              in_none;
    logic [HOLD_W-1:0] in_hold;

    modport master (
        output in_valid,
        output in_code,
        output in_none,
        output in_hold,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_code,
        input  in_none,
        input  in_hold,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/onehot_decoder_seq.sv
`default_nettype none
// ============================================================================
// Module   : onehot_decoder_seq
// Brief    : Handshaked 3-to-8 one-hot decoder holding each word for
//            in_hold+1 cycles and counting completed drives.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_decoder_seq #(
    parameter int IN_W   = 3,
    parameter int OUT_W  = 8,
    parameter int HOLD_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    onehot_decoder_seq_if.slave  req,
    output logic [OUT_W-1:0]     y,
    output logic                 y_valid,
    output logic [7:0]           done_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [OUT_W-1:0]  r_y;
    logic [OUT_W-1:0]  w_y_nxt;
    logic              r_y_valid;
    logic              w_y_valid_nxt;
    logic [HOLD_W-1:0] r_cnt;
    logic [HOLD_W-1:0] w_cnt_nxt;
    logic [7:0]        r_done_cnt;
    logic [7:0]        w_done_cnt_nxt;

    logic [OUT_W-1:0]  w_onehot;
    logic              w_ready;
    logic              w_accept;

    // in_none forces an all-zero word regardless of in_code.
    generate
        for (genvar i = 0; i < OUT_W; i++) begin : g_onehot
            assign w_onehot[i] = !req.in_none && (req.in_code == IN_W'(i));
        end
    endgenerate

    assign w_ready  = (r_state == ST_IDLE) || (r_cnt == '0);
    assign w_accept = req.in_valid && w_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_y_nxt        = r_y;
        w_y_valid_nxt  = r_y_valid;
        w_cnt_nxt      = r_cnt;
        w_done_cnt_nxt = r_done_cnt;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_y_nxt       = w_onehot;
                    w_y_valid_nxt = 1'b1;
                    w_cnt_nxt     = req.in_hold;
                    w_state_nxt   = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_done_cnt_nxt = r_done_cnt + 8'd1;
                    if (w_accept) begin
                        w_y_nxt       = w_onehot;
                        w_y_valid_nxt = 1'b1;
                        w_cnt_nxt     = req.in_hold;
                    end else begin
                        w_y_nxt       = '0;
                        w_y_valid_nxt = 1'b0;
                        w_state_nxt   = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_y_nxt       = '0;
                w_y_valid_nxt = 1'b0;
                w_cnt_nxt     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_y        <= '0;
            r_y_valid  <= 1'b0;
            r_cnt      <= '0;
            r_done_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_y        <= w_y_nxt;
            r_y_valid  <= w_y_valid_nxt;
            r_cnt      <= w_cnt_nxt;
            r_done_cnt <= w_done_cnt_nxt;
        end
    end

    assign req.in_ready = w_ready;
    assign y            = r_y;
    assign y_valid      = r_y_valid;
    assign done_cnt     = r_done_cnt;

endmodule
`default_nettype wire

// File: tb/tb_onehot_decoder_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_onehot_decoder_seq
// Brief    : Directed self-checking bench for onehot_decoder_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_onehot_decoder_seq;

    logic       clk;
    logic       rst_n;
    logic [7:0] y;
    logic       y_valid;
    logic [7:0] done_cnt;

    int         checks;
    int         errors;
    logic [7:0] exp_done;

    onehot_decoder_seq_if #(.IN_W(3), .HOLD_W(4)) req_if ();

    onehot_decoder_seq #(
        .IN_W   (3),
        .OUT_W  (8),
        .HOLD_W (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req_if),
        .y        (y),
        .y_valid  (y_valid),
        .done_cnt (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n          = 1'b0;
        req_if.in_valid = 1'b1;
        req_if.in_code  = 3'd4;
        req_if.in_none  = 1'b0;
        req_if.in_hold  = 4'd0;
        #1;
        checks++; if (y !== 8'h00) begin errors++; $display("FAIL reset_y: got %h expected %h", y, 8'h00); end
        checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_y_valid: got %b expected 0", y_valid); end
        checks++; if (done_cnt !== 8'd0) begin errors++; $display("FAIL reset_done: got %0d expected 0", done_cnt); end
        checks++; if (req_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_if.in_ready); end
        tick();
        tick();
        checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_hold_valid: got %b expected 0", y_valid); end
        rst_n = 1'b1;
        tick();
        checks++; if (y !== 8'h10) begin errors++; $display("FAIL release_y: got %h expected %h", y, 8'h10); end
        checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL release_y_valid: got %b expected 1", y_valid); end
        req_if.in_valid = 1'b0;
        tick();
        exp_done = 8'd1;
        checks++; if (y !== 8'h00 || y_valid !== 1'b0) begin errors++; $display("FAIL release_end: got y=%h v=%b expected y=00 v=0", y, y_valid); end
        checks++; if (done_cnt !== exp_done) begin errors++; $display("FAIL release_done: got %0d expected %0d", done_cnt, exp_done); end
    endtask

    task automatic test_sweep;
        logic [7:0] exp_y;
        req_if.in_valid = 1'b1;
        req_if.in_none  = 1'b0;
        req_if.in_hold  = 4'd0;
        req_if.in_code  = 3'd7;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_y = 8'h80 >> i;
            checks++; if (y !== exp_y) begin errors++; $display("FAIL sweep_y[%0d]: got %h expected %h", i, y, exp_y); end
            checks++; if (y_valid !== 1'b1 || req_if.in_ready !== 1'b1) begin errors++; $display("FAIL sweep_vr[%0d]: got v=%b r=%b expected 1 1", i, y_valid, req_if.in_ready); end
            if (i < 7) req_if.in_code = 3'(6 - i);
            else       req_if.in_valid = 1'b0;
        end
        tick();
        exp_done = exp_done + 8'd8;
        checks++; if (y_valid !== 1'b0 || y !== 8'h00) begin errors++; $display("FAIL sweep_end: got y=%h v=%b expected y=00 v=0", y, y_valid); end
        checks++; if (done_cnt !== exp_done) begin errors++; $display("FAIL sweep_done: got %0d expected %0d", done_cnt, exp_done); end
    endtask

    task automatic test_hold;
        req_if.in_valid = 1'b1;
        req_if.in_code  = 3'd5;
        req_if.in_hold  = 4'd3;
        for (int j = 0; j < 4; j++) begin
            tick();
            // A new request is posted immediately; it must wait for cnt==0.
            if (j == 0) begin
                req_if.in_code = 3'd2;
                req_if.in_hold = 4'd0;
            end
            checks++; if (y !== 8'h20 || y_valid !== 1'b1) begin errors++; $display("FAIL hold_y[%0d]: got y=%h v=%b expected y=20 v=1", j, y, y_valid); end
            checks++; if (req_if.in_ready !== (j == 3)) begin errors++; $display("FAIL hold_ready[%0d]: got %b expected %b", j, req_if.in_ready, (j == 3)); end
        end
        tick();
        req_if.in_valid = 1'b0;
        exp_done = exp_done + 8'd1;
        checks++; if (y !== 8'h04 || y_valid !== 1'b1) begin errors++; $display("FAIL hold_next_y: got y=%h v=%b expected y=04 v=1", y, y_valid); end
        checks++; if (done_cnt !== exp_done) begin errors++; $display("FAIL hold_done: got %0d expected %0d", done_cnt, exp_done); end
        tick();
        exp_done = exp_done + 8'd1;
        checks++; if (y !== 8'h00 || y_valid !== 1'b0) begin errors++; $display("FAIL hold_end: got y=%h v=%b expected y=00 v=0", y, y_valid); end
        checks++; if (done_cnt !== exp_done) begin errors++; $display("FAIL hold_end_done: got %0d expected %0d", done_cnt, exp_done); end
    endtask

    task automatic test_none;
        req_if.in_valid = 1'b1;
        req_if.in_none  = 1'b1;
        req_if.in_code  = 3'd6;
        req_if.in_hold  = 4'd1;
        tick();
        req_if.in_valid = 1'b0;
        req_if.in_none  = 1'b0;
        checks++; if (y !== 8'h00 || y_valid !== 1'b1) begin errors++; $display("FAIL none_c0: got y=%h v=%b expected y=00 v=1", y, y_valid); end
        checks++; if (req_if.in_ready !== 1'b0) begin errors++; $display("FAIL none_ready: got %b expected 0", req_if.in_ready); end
        tick();
        checks++; if (y !== 8'h00 || y_valid !== 1'b1) begin errors++; $display("FAIL none_c1: got y=%h v=%b expected y=00 v=1", y, y_valid); end
        tick();
        exp_done = exp_done + 8'd1;
        checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL none_end: got v=%b expected 0", y_valid); end
        checks++; if (done_cnt !== exp_done) begin errors++; $display("FAIL none_done: got %0d expected %0d", done_cnt, exp_done); end
    endtask

    task automatic test_mid_reset;
        req_if.in_valid = 1'b1;
        req_if.in_code  = 3'd3;
        req_if.in_hold  = 4'd15;
        tick();
        req_if.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        checks++; if (y !== 8'h08 || y_valid !== 1'b1) begin errors++; $display("FAIL mid_pre: got y=%h v=%b expected y=08 v=1", y, y_valid); end
        checks++; if (done_cnt !== exp_done) begin errors++; $display("FAIL mid_pre_done: got %0d expected %0d", done_cnt, exp_done); end
        #2;
        rst_n = 1'b0;
        #1;
        exp_done = 8'd0;
        checks++; if (y !== 8'h00 || y_valid !== 1'b0) begin errors++; $display("FAIL mid_async: got y=%h v=%b expected y=00 v=0", y, y_valid); end
        checks++; if (done_cnt !== exp_done) begin errors++; $display("FAIL mid_done_clear: got %0d expected 0", done_cnt); end
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        checks++; if (y_valid !== 1'b0 || done_cnt !== exp_done) begin errors++; $display("FAIL mid_after: got v=%b done=%0d expected v=0 done=0", y_valid, done_cnt); end
    endtask

    task automatic test_wrap;
        logic [7:0] exp_y;
        int         bad;
        bad = 0;
        req_if.in_valid = 1'b1;
        req_if.in_none  = 1'b0;
        req_if.in_hold  = 4'd0;
        req_if.in_code  = 3'd0;
        for (int i = 0; i < 256; i++) begin
            tick();
            exp_y = 8'h01 << (i % 8);
            if (y !== exp_y || y_valid !== 1'b1 || done_cnt !== 8'(i)) bad++;
            req_if.in_code = 3'((i + 1) % 8);
            if (i == 255) req_if.in_valid = 1'b0;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL wrap_stream: got %0d bad cycles expected 0", bad); end
        checks++; if (done_cnt !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d expected 255", done_cnt); end
        tick();
        checks++; if (done_cnt !== 8'd0) begin errors++; $display("FAIL wrap_0: got %0d expected 0", done_cnt); end
        checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL wrap_end: got v=%b expected 0", y_valid); end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        exp_done = 8'd0;
        test_reset();
        test_sweep();
        test_hold();
        test_none();
        test_mid_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
